mem_read_sequencer: RTL and testbench
=====================================

Name: mem_read_sequencer

Overview:
- Upstream neighbour of the lab `memory` block.
- Drives the memory address for a block read of `count` consecutive words starting at `base_addr`.
- Captures the memory's `data_out` after the fixed read latency.
- Presents each word to a downstream consumer over a valid/ready handshake, with start/busy/done control towards the test or control logic.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 8, memory data width; matches memory `data_out`.
- RD_LATENCY, 2, rising edges from the address register update to the edge at which `mem_data` is valid for capture. Legal values 1..4.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a block read; sampled only in IDLE.
- base_addr  in  ADDR_W  first address, latched on accepted start.
- count  in  ADDR_W+1  number of words to read, latched on accepted start; 0 is legal.
- address  out  ADDR_W  registered address to memory.
- mem_data  in  DATA_W  memory `data_out`.
- out_data  out  DATA_W  captured word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- busy  out  1  high from accepted start until DONE is left.
- done  out  1  one-cycle pulse when the block read completes.

Behaviour:
- Reset values, applied asynchronously: state=IDLE, address=0, out_data=0, out_valid=0, busy=0, done=0, remaining=0, lat_cnt=0.
- Reset mid-operation aborts immediately. out_valid drops without a handshake and no done pulse is issued.
- IDLE:
  - start=1 and count=0 -> DONE.
  - start=1 and count>0 -> address<=base_addr, remaining<=count, lat_cnt<=0, busy<=1, go to WAIT.
  - start=0 -> stay in IDLE.
- WAIT:
  - lat_cnt increments each edge.
  - On the edge where lat_cnt==RD_LATENCY-1: out_data<=mem_data, out_valid<=1, go to HOLD.
  - With the default of 2, data is captured 2 edges after the address updates.
- HOLD:
  - out_valid=1; address and out_data are held stable.
  - out_ready=1 -> out_valid<=0 and remaining decrements.
    - If remaining==1 -> DONE.
    - Otherwise address<=address+1 (mod 2^ADDR_W, wraps 31->0), lat_cnt<=0, go to WAIT.
  - out_ready=0 -> stay in HOLD indefinitely, with no change to any output.
- DONE: done=1 for exactly one cycle; next edge busy<=0 and go to IDLE.
- start while busy is ignored, including start asserted in the DONE cycle.
- count > 2^ADDR_W: reads continue past the wrap and re-read low addresses; no error.
- Throughput: at most one word per RD_LATENCY+1 cycles; no read pipelining.
- out_ready while out_valid=0 has no effect.
- address changes only in the IDLE->WAIT and HOLD->WAIT transitions.

Decomposition:
- Shared package `laoc_pkg`:
  - ADDR_W and DATA_W defaults, shared with the memory block.
  - State enum {IDLE, WAIT, HOLD, DONE}, encoded in 2 bits.
  - RD_LATENCY default constant.
- No sub-module; a single FSM plus counters is natural.
- The bench reuses the existing `memory` block or a behavioural model with a registered address.

Test Plan:
- Basic read:
  - Stimulus: memory preloaded mem[i]=3*i+1; base_addr=4, count=3, out_ready=1 held.
  - Response: words 13, 16, 19 each valid for 1 cycle, 3 cycles apart; done pulses once, 1 cycle after the last handshake; busy low afterwards.
- Back-pressure:
  - Stimulus: base_addr=0, count=2; out_ready=0 for 10 cycles after the first out_valid.
  - Response: out_data=1 and address=0 held stable for all 10 cycles; after release the second word is 4.
- Wrap-around:
  - Stimulus: base_addr=30, count=4.
  - Response: addresses 30, 31, 0, 1; data 91, 94, 1, 4.
- Zero count and ignored start:
  - Stimulus: count=0 start, then a start pulse during a count=5 read.
  - Response: the count=0 start gives a done pulse 1 cycle after start and no out_valid; the count=5 read produces exactly 5 words and the second start has no effect.
- Reset mid-read:
  - Stimulus: assert reset asynchronously (between edges) while in HOLD with out_valid=1.
  - Response: out_valid, busy and address go to 0 before the next edge, and no done pulse follows; a subsequent start at base_addr=2, count=1 returns 7.

Source files
------------

// File: rtl/laoc_pkg.sv
// ----------------------------------------------------------------------------
// laoc_pkg
// Shared definitions for the lab memory path: default address/data widths
// (shared with the `memory` block), the default memory read latency, and the
// state encoding of the read sequencer FSM.
// ----------------------------------------------------------------------------
package laoc_pkg;

   // Memory geometry shared with the `memory` block (32 words of 8 bits).
   localparam int LAOC_ADDR_W     = 5;
   localparam int LAOC_DATA_W     = 8;

   // Rising edges from an address register update to the edge at which the
   // memory's data_out may be captured. Legal range 1..4.
   localparam int LAOC_RD_LATENCY = 2;

   // Width of the latency counter. It must hold the capture value
   // (RD_LATENCY-1, at most 3) plus the post-capture increment (at most 4).
   localparam int LAOC_LAT_W      = 3;

   // Sequencer states, 2-bit encoding.
   //   IDLE : waiting for start
   //   WAIT : address presented, counting down the read latency
   //   HOLD : word captured and offered downstream (out_valid=1)
   //   DONE : one-cycle completion state (done=1)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage : laoc_pkg

// File: rtl/mem_read_sequencer.sv
// ----------------------------------------------------------------------------
// mem_read_sequencer
// Reads `count` consecutive words from the lab `memory` block starting at
// `base_addr`, one word at a time (no read pipelining), and hands each word to
// a downstream consumer over a valid/ready handshake.
//
// Handshake: out_valid is raised when a word is captured and stays high, with
// out_data and address frozen, until a rising edge sees out_ready=1. That edge
// is the transfer. out_ready is ignored while out_valid=0.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset (aborts any read, no done)
//   start      in   request to begin a block read, sampled only in IDLE
//   base_addr  in   first word address, latched on accepted start
//   count      in   number of words (0 legal, may exceed memory size)
//   address    out  registered address to memory
//   mem_data   in   memory data_out
//   out_data   out  captured word
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   consumer accepts out_data when out_valid & out_ready
//   busy       out  high from accepted start until DONE is left
//   done       out  one-cycle completion pulse
//   state      out  current FSM state, for observation only
// ----------------------------------------------------------------------------
module mem_read_sequencer
   import laoc_pkg::*;
#(
   parameter int ADDR_W     = LAOC_ADDR_W,
   parameter int DATA_W     = LAOC_DATA_W,
   parameter int RD_LATENCY = LAOC_RD_LATENCY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output state_t            state
);

   // Value of lat_cnt on the edge at which mem_data is captured.
   localparam logic [LAOC_LAT_W-1:0] LAT_LAST = LAOC_LAT_W'(RD_LATENCY - 1);

   logic [ADDR_W:0]       remaining;
   logic [LAOC_LAT_W-1:0] lat_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         address   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         lat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (count == '0) begin
                     // Empty block: complete straight away, memory untouched.
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     address   <= base_addr;
                     remaining <= count;
                     lat_cnt   <= '0;
                     state     <= WAIT;
                  end
               end
            end

            WAIT: begin
               // Counter keeps running on the capture edge; it is cleared
               // again whenever the next read is launched.
               lat_cnt <= lat_cnt + 1'b1;
               if (lat_cnt == LAT_LAST) begin
                  out_data  <= mem_data;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end

            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  remaining <= remaining - 1'b1;
                  if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     // Natural modulo-2^ADDR_W wrap; counts larger than the
                     // memory simply re-read the low addresses.
                     address <= address + 1'b1;
                     lat_cnt <= '0;
                     state   <= WAIT;
                  end
               end
            end

            DONE: begin
               // start is deliberately not looked at here.
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : mem_read_sequencer

// File: tb/tb_mem_read_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mem_read_sequencer
// Directed bench for mem_read_sequencer. A behavioural memory with a
// registered address (two edges of read latency) is preloaded with
// mem[i] = 3*i + 1. A table of block reads with hand-computed word lists is
// applied in a loop; back-pressure and mid-read reset are hand sequences.
// ----------------------------------------------------------------------------
module tb_mem_read_sequencer;
   import laoc_pkg::*;

   localparam int AW = LAOC_ADDR_W;
   localparam int DW = LAOC_DATA_W;

   // ---------------------------------------------------------------- clock/reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int cycle = 0;
   always @(posedge clock) cycle <= cycle + 1;

   // ---------------------------------------------------------------- DUT
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   count = '0;
   logic [AW-1:0] address;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          busy;
   logic          done;
   state_t        state;

   mem_read_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .address   (address),
      .mem_data  (mem_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .state     (state)
   );

   // ---------------------------------------------------------------- memory model
   logic [DW-1:0] mem [0:31];
   logic [AW-1:0] mem_addr_q = '0;
   initial for (int i = 0; i < 32; i++) mem[i] = DW'(3 * i + 1);
   always @(posedge clock) mem_addr_q <= address;
   assign mem_data = mem[mem_addr_q];

   // ---------------------------------------------------------------- checking
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for out_valid (cycle %0d)", name, cycle);
   endtask

   // Poll for out_valid at negedges, at most 20 cycles. Returns 1 on success.
   task automatic wait_valid(output bit ok);
      int t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clock);
         start = 1'b0;
         t++;
      end
      ok = out_valid;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   cnt;
      bit            poke;   // pulse start mid-read and in the DONE cycle
      logic [63:0]   words;  // expected words, word k in bits [8k+7:8k]
   } vec_t;

   vec_t vecs[6];

   // Runs one block read with out_ready held high and checks every word,
   // its address, the 3-cycle spacing, the done pulse and busy release.
   task automatic run_vec(input vec_t v);
      bit ok;
      int last_cyc = 0;
      logic [DW-1:0] exp_w;
      @(negedge clock);
      out_ready = 1'b1;
      base_addr = v.base;
      count     = v.cnt;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      if (v.cnt == 0) begin
         chk("zero_done", done, 1);
         chk("zero_no_valid", out_valid, 0);
         @(negedge clock);
         chk("zero_done_drop", done, 0);
         chk("zero_busy_drop", busy, 0);
         return;
      end
      for (int w = 0; w < int'(v.cnt); w++) begin
         wait_valid(ok);
         if (!ok) begin
            timeout_fail("vec_word");
            return;
         end
         exp_w = v.words[w*8 +: 8];
         chk("word_data", out_data, exp_w);
         chk("word_addr", address, AW'(v.base + w));
         chk("done_low_in_hold", done, 0);
         if (w > 0) chk("word_spacing", cycle - last_cyc, 3);
         last_cyc = cycle;
         @(negedge clock);  // handshake edge has passed
         chk("valid_one_cycle", out_valid, 0);
         if (v.poke && w == 0) begin
            start     = 1'b1;
            base_addr = '0;
            count     = 2;
         end
         if (w == int'(v.cnt) - 1) begin
            chk("done_pulse", done, 1);
            if (v.poke) start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            chk("done_one_cycle", done, 0);
            chk("busy_released", busy, 0);
            @(negedge clock);
            chk("idle_after_done_busy", busy, 0);
            chk("idle_after_done_valid", out_valid, 0);
         end
      end
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      bit   ok;
      vec_t v;

      vecs[0] = '{base: 5'd4,  cnt: 6'd3, poke: 1'b0, words: {40'd0, 8'd19, 8'd16, 8'd13}};
      vecs[1] = '{base: 5'd30, cnt: 6'd4, poke: 1'b0, words: {32'd0, 8'd4, 8'd1, 8'd94, 8'd91}};
      vecs[2] = '{base: 5'd10, cnt: 6'd1, poke: 1'b0, words: {56'd0, 8'd31}};
      vecs[3] = '{base: 5'd7,  cnt: 6'd0, poke: 1'b0, words: 64'd0};
      vecs[4] = '{base: 5'd8,  cnt: 6'd5, poke: 1'b1, words: {24'd0, 8'd37, 8'd34, 8'd31, 8'd28, 8'd25}};
      vecs[5] = '{base: 5'd31, cnt: 6'd2, poke: 1'b0, words: {48'd0, 8'd1, 8'd94}};

      // Reset state
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_state", state, IDLE);
      chk("rst_address", address, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Back-pressure: base 0, count 2, consumer stalls 10 cycles on word 0
      @(negedge clock);
      out_ready = 1'b0;
      base_addr = 5'd0;
      count     = 6'd2;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_valid(ok);
      if (!ok) timeout_fail("bp_first");
      for (int c = 0; c < 10; c++) begin
         chk("bp_hold_data", out_data, 1);
         chk("bp_hold_addr", address, 0);
         chk("bp_hold_valid", out_valid, 1);
         @(negedge clock);
      end
      out_ready = 1'b1;
      @(negedge clock);
      chk("bp_released", out_valid, 0);
      wait_valid(ok);
      if (!ok) timeout_fail("bp_second");
      chk("bp_second_data", out_data, 4);
      chk("bp_second_addr", address, 1);
      @(negedge clock);
      chk("bp_done", done, 1);
      @(negedge clock);
      chk("bp_busy_drop", busy, 0);

      // Reset mid-read while holding a word
      @(negedge clock);
      out_ready = 1'b0;
      base_addr = 5'd3;
      count     = 6'd3;
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_valid(ok);
      if (!ok) timeout_fail("rst_mid_valid");
      chk("rst_mid_pre_valid", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_addr", address, 0);
      chk("rst_mid_done", done, 0);
      @(negedge clock);
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("rst_no_done", done, 0);
         chk("rst_no_valid", out_valid, 0);
      end
      v = '{base: 5'd2, cnt: 6'd1, poke: 1'b0, words: {56'd0, 8'd7}};
      run_vec(v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_mem_read_sequencer
